gpu_blitter: RTL and testbench

- Second-generation 2D drawing engine between the CPU command registers, video memory and the framebuffer write port.
- Executes three commands:
  - DRAW: rectangular image excerpt from memory, with optional X/Y mirroring.
  - FILL: solid-colour rectangle.
  - CLEAR: whole framebuffer.
- Adds over the first generation: latched command registers, a pipelined memory read port with bounded outstanding requests, parametrised colour width, and a done pulse.

---
 rtl/gpu_blitter.sv | 225 ++++++++++++++++++++++
 tb/tb_gpu_blitter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_blitter.sv
// 2D blitter: DRAW (memory excerpt, optional mirroring), FILL and CLEAR into a framebuffer port.
// Optional colour-key transparency for DRAW is enabled with GPU_BLITTER_COLOR_KEY_EN.
module gpu_blitter #(
    parameter int unsigned FB_WIDTH        = 400,
    parameter int unsigned FB_HEIGHT       = 240,
    parameter int unsigned COLOR_W         = 16,
    parameter int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned XW = $clog2(FB_WIDTH) + 2,
    localparam int unsigned YW = $clog2(FB_HEIGHT) + 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic [31:0]        mem_addr,
    output logic               mem_req,
    input  logic               mem_ready,
    input  logic [COLOR_W-1:0] mem_data,
    input  logic               mem_valid,
    input  logic [1:0]         ctrl_mode,
    input  logic [31:0]        ctrl_address,
    input  logic [15:0]        ctrl_address_x,
    input  logic [15:0]        ctrl_address_y,
    input  logic [15:0]        ctrl_image_width,
    input  logic [XW-1:0]      ctrl_width,
    input  logic [YW-1:0]      ctrl_height,
    input  logic [XW-1:0]      ctrl_x,
    input  logic [YW-1:0]      ctrl_y,
    input  logic               ctrl_flip_x,
    input  logic               ctrl_flip_y,
    input  logic [COLOR_W-1:0] ctrl_color,
`ifdef GPU_BLITTER_COLOR_KEY_EN
    input  logic [COLOR_W-1:0] ctrl_color_key,
`endif
    input  logic               ctrl_start,
    output logic               ctrl_busy,
    output logic               ctrl_done,
    output logic [XW-2:0]      fb_x,
    output logic [YW-2:0]      fb_y,
    output logic [COLOR_W-1:0] fb_color,
    output logic               fb_write
);

    typedef enum logic [1:0] {StIdle, StSweep, StFetch, StDone} state_t;

    state_t             r_state, w_next_state;
    logic [15:0]        r_stride;
    logic               r_fx, r_fy;
    logic [XW-1:0]      r_w, r_x, r_ii, r_wi;
    logic [YW-1:0]      r_h, r_y, r_ij, r_wj;
    logic [COLOR_W-1:0] r_color;
    logic               r_iss_done, r_wr_done;
    logic [31:0]        r_mem_addr, r_row_addr;
    logic [3:0]         r_outst;
    logic [XW-2:0]      r_fb_x;
    logic [YW-2:0]      r_fb_y;
    logic [COLOR_W-1:0] r_fb_color;
    logic               r_fb_write;
`ifdef GPU_BLITTER_COLOR_KEY_EN
    logic [COLOR_W-1:0] r_key;
`endif

    logic               w_accept, w_issue, w_resp, w_step, w_zero;
    logic [31:0]        w_sx0, w_sy0, w_addr0, w_next_row;
    logic [COLOR_W-1:0] w_pix_color;
    logic               w_opaque, w_in_range;
    logic [XW:0]        w_ux;
    logic [YW:0]        w_uy;

    assign w_accept  = ctrl_start && (r_state == StIdle || r_state == StDone);
    assign ctrl_busy = (r_state == StSweep) || (r_state == StFetch);
    assign ctrl_done = (r_state == StDone);
    assign mem_req   = (r_state == StFetch) && !r_iss_done && (r_outst < 4'(MAX_OUTSTANDING));
    assign mem_addr  = r_mem_addr;
    assign w_issue   = mem_req && mem_ready;
    assign w_resp    = mem_valid && (r_outst != 4'd0);
    assign w_step    = !r_wr_done && ((r_state == StSweep) || ((r_state == StFetch) && w_resp));
    assign w_zero    = (ctrl_width == '0) || (ctrl_height == '0);

    // Address of the first issued pixel, taken straight from the command inputs.
    assign w_sx0   = ctrl_flip_x ? 32'(ctrl_width) - 32'd1 : 32'd0;
    assign w_sy0   = ctrl_flip_y ? 32'(ctrl_height) - 32'd1 : 32'd0;
    assign w_addr0 = ctrl_address + 32'(ctrl_address_x) + w_sx0
                   + (32'(ctrl_address_y) + w_sy0) * 32'(ctrl_image_width);
    assign w_next_row = r_fy ? r_row_addr - 32'(r_stride) : r_row_addr + 32'(r_stride);

    assign w_pix_color = (r_state == StFetch) ? mem_data : r_color;
`ifdef GPU_BLITTER_COLOR_KEY_EN
    assign w_opaque = (r_state == StFetch) ? (mem_data != r_key) : 1'b1;
`else
    assign w_opaque = w_pix_color[0];
`endif
    assign w_ux       = {1'b0, r_x} + {1'b0, r_wi};
    assign w_uy       = {1'b0, r_y} + {1'b0, r_wj};
    assign w_in_range = (w_ux < (XW+1)'(FB_WIDTH)) && (w_uy < (YW+1)'(FB_HEIGHT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= StIdle;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            StIdle, StDone: begin
                if (r_state == StDone) w_next_state = StIdle;
                if (w_accept) begin
                    if (ctrl_mode == 2'd3 || (ctrl_mode != 2'd2 && w_zero)) begin
                        w_next_state = StDone;
                    end else if (ctrl_mode == 2'd0) begin
                        w_next_state = StFetch;
                    end else begin
                        w_next_state = StSweep;
                    end
                end
            end
            StSweep, StFetch: if (r_wr_done) w_next_state = StDone;
            default:          w_next_state = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stride   <= '0;
            r_fx       <= 1'b0;
            r_fy       <= 1'b0;
            r_w        <= '0;
            r_h        <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_color    <= '0;
            r_ii       <= '0;
            r_ij       <= '0;
            r_wi       <= '0;
            r_wj       <= '0;
            r_iss_done <= 1'b0;
            r_wr_done  <= 1'b0;
            r_mem_addr <= '0;
            r_row_addr <= '0;
`ifdef GPU_BLITTER_COLOR_KEY_EN
            r_key      <= '0;
`endif
        end else if (w_accept) begin
            r_stride   <= ctrl_image_width;
            r_fx       <= ctrl_flip_x;
            r_fy       <= ctrl_flip_y;
            r_color    <= ctrl_color;
            r_ii       <= '0;
            r_ij       <= '0;
            r_wi       <= '0;
            r_wj       <= '0;
            r_iss_done <= 1'b0;
            r_wr_done  <= 1'b0;
            r_mem_addr <= w_addr0;
            r_row_addr <= w_addr0;
`ifdef GPU_BLITTER_COLOR_KEY_EN
            r_key      <= ctrl_color_key;
`endif
            if (ctrl_mode == 2'd2) begin
                r_w <= XW'(FB_WIDTH);
                r_h <= YW'(FB_HEIGHT);
                r_x <= '0;
                r_y <= '0;
            end else begin
                r_w <= ctrl_width;
                r_h <= ctrl_height;
                r_x <= ctrl_x;
                r_y <= ctrl_y;
            end
        end else begin
            if (w_issue) begin
                if (r_ii == r_w - XW'(1)) begin
                    r_ii       <= '0;
                    r_row_addr <= w_next_row;
                    r_mem_addr <= w_next_row;
                    if (r_ij == r_h - YW'(1)) r_iss_done <= 1'b1;
                    else                      r_ij       <= r_ij + YW'(1);
                end else begin
                    r_ii       <= r_ii + XW'(1);
                    r_mem_addr <= r_fx ? r_mem_addr - 32'd1 : r_mem_addr + 32'd1;
                end
            end
            // Write counter: one step per sweep cycle or per accepted response.
            if (w_step) begin
                if (r_wi == r_w - XW'(1)) begin
                    r_wi <= '0;
                    if (r_wj == r_h - YW'(1)) r_wr_done <= 1'b1;
                    else                      r_wj      <= r_wj + YW'(1);
                end else begin
                    r_wi <= r_wi + XW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outst <= '0;
        end else if (w_issue && !w_resp) begin
            r_outst <= r_outst + 4'd1;
        end else if (!w_issue && w_resp) begin
            r_outst <= r_outst - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fb_write <= 1'b0;
            r_fb_x     <= '0;
            r_fb_y     <= '0;
            r_fb_color <= '0;
        end else begin
            r_fb_write <= w_step && w_opaque && w_in_range;
            if (w_step) begin
                r_fb_x     <= w_ux[XW-2:0];
                r_fb_y     <= w_uy[YW-2:0];
                r_fb_color <= w_pix_color;
            end
        end
    end

    assign fb_x     = r_fb_x;
    assign fb_y     = r_fb_y;
    assign fb_color = r_fb_color;
    assign fb_write = r_fb_write;

endmodule

// File: tb/tb_gpu_blitter.sv
// Directed self-checking bench for gpu_blitter with a fixed-latency memory model.
module tb_gpu_blitter;
    localparam int XW = 11;
    localparam int YW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   mem_addr;
    logic          mem_req;
    logic          mem_ready = 1'b1;
    logic [15:0]   mem_data = '0;
    logic          mem_valid = 1'b0;
    logic [1:0]    ctrl_mode = '0;
    logic [31:0]   ctrl_address = '0;
    logic [15:0]   ctrl_address_x = '0;
    logic [15:0]   ctrl_address_y = '0;
    logic [15:0]   ctrl_image_width = '0;
    logic [XW-1:0] ctrl_width = '0;
    logic [YW-1:0] ctrl_height = '0;
    logic [XW-1:0] ctrl_x = '0;
    logic [YW-1:0] ctrl_y = '0;
    logic          ctrl_flip_x = 1'b0;
    logic          ctrl_flip_y = 1'b0;
    logic [15:0]   ctrl_color = '0;
`ifdef GPU_BLITTER_COLOR_KEY_EN
    logic [15:0]   ctrl_color_key = 16'hFFFE;
`endif
    logic          ctrl_start = 1'b0;
    logic          ctrl_busy;
    logic          ctrl_done;
    logic [XW-2:0] fb_x;
    logic [YW-2:0] fb_y;
    logic [15:0]   fb_color;
    logic          fb_write;

    gpu_blitter dut (
        .clk(clk), .reset(reset),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_ready(mem_ready),
        .mem_data(mem_data), .mem_valid(mem_valid),
        .ctrl_mode(ctrl_mode), .ctrl_address(ctrl_address),
        .ctrl_address_x(ctrl_address_x), .ctrl_address_y(ctrl_address_y),
        .ctrl_image_width(ctrl_image_width), .ctrl_width(ctrl_width),
        .ctrl_height(ctrl_height), .ctrl_x(ctrl_x), .ctrl_y(ctrl_y),
        .ctrl_flip_x(ctrl_flip_x), .ctrl_flip_y(ctrl_flip_y), .ctrl_color(ctrl_color),
`ifdef GPU_BLITTER_COLOR_KEY_EN
        .ctrl_color_key(ctrl_color_key),
`endif
        .ctrl_start(ctrl_start), .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done),
        .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .fb_write(fb_write)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_wr, n_done, n_busy, last_wr_cyc, done_cyc;
    logic [XW-2:0] last_x;
    logic [YW-2:0] last_y;
    logic [15:0]   last_c;
    logic [31:0]   iss_q[$];
    logic [XW-2:0] wx_q[$];
    logic [YW-2:0] wy_q[$];
    logic [15:0]   wc_q[$];
    bit stall = 0, stray = 0, transp = 0;

    typedef struct { int due; logic [15:0] data; } resp_t;
    resp_t mq[$];

    // Monitor and memory model share one negedge process so cycle stamps agree.
    always @(negedge clk) begin
        cyc++;
        if (fb_write) begin
            n_wr++;
            last_x = fb_x; last_y = fb_y; last_c = fb_color; last_wr_cyc = cyc;
            if (wx_q.size() < 64) begin
                wx_q.push_back(fb_x); wy_q.push_back(fb_y); wc_q.push_back(fb_color);
            end
        end
        if (mem_req && mem_ready && iss_q.size() < 64) iss_q.push_back(mem_addr);
        if (ctrl_done) begin n_done++; done_cyc = cyc; end
        if (ctrl_busy) n_busy++;
        mem_valid = 1'b0;
        if (reset) begin
            mq.delete();
        end else if (stray) begin
            mem_valid = 1'b1; mem_data = 16'h0001;
        end else if (!stall && mq.size() > 0 && mq[0].due <= cyc) begin
            mem_valid = 1'b1; mem_data = mq[0].data; void'(mq.pop_front());
        end
        if (!reset && mem_req && mem_ready)
            mq.push_back('{due: cyc + 3,
                           data: transp ? mem_addr[15:0] : (mem_addr[15:0] | 16'h0001)});
    end

    task automatic clear_mon();
        n_wr = 0; n_done = 0; n_busy = 0; last_wr_cyc = 0; done_cyc = 0;
        iss_q.delete(); wx_q.delete(); wy_q.delete(); wc_q.delete();
    endtask

    task automatic start_cmd(input logic [1:0] mode, input logic [31:0] addr,
                             input logic [15:0] ax, input logic [15:0] ay,
                             input logic [15:0] stride, input logic [XW-1:0] w,
                             input logic [YW-1:0] h, input logic [XW-1:0] x,
                             input logic [YW-1:0] y, input logic fx, input logic fy,
                             input logic [15:0] color);
        @(posedge clk); #1;
        ctrl_mode = mode; ctrl_address = addr; ctrl_address_x = ax; ctrl_address_y = ay;
        ctrl_image_width = stride; ctrl_width = w; ctrl_height = h; ctrl_x = x; ctrl_y = y;
        ctrl_flip_x = fx; ctrl_flip_y = fy; ctrl_color = color; ctrl_start = 1'b1;
        @(posedge clk); #1;
        ctrl_start = 1'b0;
        // Scramble inputs to prove the command was latched.
        ctrl_address = 32'hDEAD0000; ctrl_address_x = 16'h55; ctrl_address_y = 16'h77;
        ctrl_image_width = 16'h3; ctrl_width = 11'd1; ctrl_height = 10'd1;
        ctrl_x = 11'd300; ctrl_y = 10'd100; ctrl_flip_x = ~fx; ctrl_flip_y = ~fy;
        ctrl_color = 16'h0000;
    endtask

    task automatic wait_done(input int max_cyc, input string name);
        int k;
        k = 0;
        while (!ctrl_done && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!ctrl_done) begin
            failures++;
            $display("FAIL %s_timeout: no ctrl_done within %0d cycles", name, max_cyc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({mem_req, mem_addr, ctrl_busy, ctrl_done, fb_x, fb_y, fb_color, fb_write} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got req=%0b addr=%0h busy=%0b done=%0b wr=%0b, want all 0",
                     mem_req, mem_addr, ctrl_busy, ctrl_done, fb_write);
        end
        reset = 1'b0;
    endtask

    task automatic test_draw(input logic flip);
        logic [31:0] ea;
        clear_mon();
        transp = 0;
        start_cmd(2'd0, 32'h1000, 16'd2, 16'd3, 16'd64, 11'd4, 10'd2, 11'd10, 10'd20,
                  flip, flip, 16'h0);
        checks++;
        if (ctrl_busy !== 1'b1) begin
            failures++; $display("FAIL draw_busy: got %0b want 1", ctrl_busy);
        end
        wait_done(200, "draw");
        checks++;
        if (iss_q.size() != 8 || n_wr != 8) begin
            failures++;
            $display("FAIL draw_counts: got issues=%0d writes=%0d want 8/8", iss_q.size(), n_wr);
        end
        for (int k = 0; k < 8; k++) begin
            if (!flip) ea = (k < 4) ? 32'h10C2 + 32'(k) : 32'h1102 + 32'(k - 4);
            else       ea = (k < 4) ? 32'h1105 - 32'(k) : 32'h10C5 - 32'(k - 4);
            checks++;
            if (iss_q[k] !== ea) begin
                failures++; $display("FAIL draw_addr[%0d]: got %0h want %0h", k, iss_q[k], ea);
            end
            checks++;
            if (wx_q[k] !== 10'(10 + k % 4) || wy_q[k] !== 9'(20 + k / 4)
                || wc_q[k] !== (ea[15:0] | 16'h1)) begin
                failures++;
                $display("FAIL draw_pix[%0d]: got (%0d,%0d,%0h) want (%0d,%0d,%0h)", k, wx_q[k],
                         wy_q[k], wc_q[k], 10 + k % 4, 20 + k / 4, ea[15:0] | 16'h1);
            end
        end
    endtask

    task automatic test_transparent();
        clear_mon();
        transp = 1;
        start_cmd(2'd0, 32'h2000, 16'd0, 16'd0, 16'd16, 11'd4, 10'd1, 11'd0, 10'd0,
                  1'b0, 1'b0, 16'h0);
        wait_done(100, "transp");
        transp = 0;
        checks++;
        if (n_wr != 2 || wx_q[0] !== 10'd1 || wc_q[0] !== 16'h2001
            || wx_q[1] !== 10'd3 || wc_q[1] !== 16'h2003) begin
            failures++;
            $display("FAIL transp_writes: got n=%0d x0=%0d c0=%0h x1=%0d c1=%0h want 2,1,2001,3,2003",
                     n_wr, wx_q[0], wc_q[0], wx_q[1], wc_q[1]);
        end
    endtask

    task automatic test_stall();
        clear_mon();
        stall = 1;
        start_cmd(2'd0, 32'h3000, 16'd0, 16'd0, 16'd8, 11'd8, 10'd1, 11'd0, 10'd0,
                  1'b0, 1'b0, 16'h0);
        repeat (12) @(negedge clk);
        checks++;
        if (iss_q.size() != 4 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL stall_limit: got issues=%0d req=%0b want 4/0", iss_q.size(), mem_req);
        end
        stall = 0;
        wait_done(200, "stall");
        checks++;
        if (iss_q.size() != 8 || n_wr != 8 || iss_q[7] !== 32'h3007) begin
            failures++;
            $display("FAIL stall_complete: got issues=%0d writes=%0d last=%0h want 8/8/3007",
                     iss_q.size(), n_wr, iss_q[7]);
        end
    endtask

    task automatic test_fill();
        clear_mon();
        start_cmd(2'd1, 32'h0, 16'd0, 16'd0, 16'd0, 11'd8, 10'd4, 11'd396, 10'd238,
                  1'b0, 1'b0, 16'h0001);
        @(posedge clk); #1;
        ctrl_mode = 2'd2; ctrl_start = 1'b1;
        @(posedge clk); #1;
        ctrl_start = 1'b0;
        wait_done(100, "fill");
        checks++;
        if (n_wr != 8 || n_busy != 33 || n_done != 1) begin
            failures++;
            $display("FAIL fill_counts: got writes=%0d busy=%0d done=%0d want 8/33/1",
                     n_wr, n_busy, n_done);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (wx_q[k] !== 10'(396 + k % 4) || wy_q[k] !== 9'(238 + k / 4)
                || wc_q[k] !== 16'h0001) begin
                failures++;
                $display("FAIL fill_pix[%0d]: got (%0d,%0d,%0h) want (%0d,%0d,1)", k, wx_q[k],
                         wy_q[k], wc_q[k], 396 + k % 4, 238 + k / 4);
            end
        end
    endtask

    task automatic test_zero_size();
        clear_mon();
        start_cmd(2'd1, 32'h0, 16'd0, 16'd0, 16'd0, 11'd0, 10'd3, 11'd5, 10'd5,
                  1'b0, 1'b0, 16'h0001);
        checks++;
        if (ctrl_done !== 1'b1 || ctrl_busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_fill_done: got done=%0b busy=%0b want 1/0", ctrl_done, ctrl_busy);
        end
        start_cmd(2'd0, 32'h100, 16'd0, 16'd0, 16'd4, 11'd3, 10'd0, 11'd5, 10'd5,
                  1'b0, 1'b0, 16'h0);
        checks++;
        if (ctrl_done !== 1'b1 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL zero_draw_done: got done=%0b req=%0b want 1/0", ctrl_done, mem_req);
        end
        start_cmd(2'd3, 32'h0, 16'd0, 16'd0, 16'd0, 11'd4, 10'd4, 11'd0, 10'd0,
                  1'b0, 1'b0, 16'h0001);
        checks++;
        if (ctrl_done !== 1'b1) begin
            failures++; $display("FAIL reserved_done: got %0b want 1", ctrl_done);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (n_wr != 0 || iss_q.size() != 0 || n_done != 3 || ctrl_done !== 1'b0) begin
            failures++;
            $display("FAIL zero_quiet: got writes=%0d issues=%0d dones=%0d want 0/0/3",
                     n_wr, iss_q.size(), n_done);
        end
    endtask

    task automatic test_reset_mid_draw();
        clear_mon();
        start_cmd(2'd0, 32'h1000, 16'd2, 16'd3, 16'd64, 11'd4, 10'd2, 11'd10, 10'd20,
                  1'b0, 1'b0, 16'h0);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_req, mem_addr, ctrl_busy, ctrl_done, fb_x, fb_y, fb_color, fb_write} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs: got req=%0b addr=%0h busy=%0b wr=%0b, want all 0",
                     mem_req, mem_addr, ctrl_busy, fb_write);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        stray = 1;
        repeat (3) @(posedge clk);
        #1;
        stray = 0;
        checks++;
        if (n_done != 0 || ctrl_busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_nodone: got dones=%0d busy=%0b want 0/0", n_done, ctrl_busy);
        end
    endtask

    task automatic test_clear();
        clear_mon();
        start_cmd(2'd2, 32'h0, 16'd0, 16'd0, 16'd0, 11'd3, 10'd3, 11'd5, 10'd7,
                  1'b0, 1'b0, 16'hF801);
        stray = 1;
        repeat (4) @(posedge clk);
        #1;
        stray = 0;
        wait_done(97000, "clear");
        checks++;
        if (n_wr != 96000) begin
            failures++; $display("FAIL clear_count: got %0d want 96000", n_wr);
        end
        checks++;
        if (last_x !== 10'd399 || last_y !== 9'd239 || last_c !== 16'hF801) begin
            failures++;
            $display("FAIL clear_last: got (%0d,%0d,%0h) want (399,239,f801)",
                     last_x, last_y, last_c);
        end
        checks++;
        if (wx_q[0] !== 10'd0 || wy_q[0] !== 9'd0) begin
            failures++; $display("FAIL clear_first: got (%0d,%0d) want (0,0)", wx_q[0], wy_q[0]);
        end
        checks++;
        if (done_cyc != last_wr_cyc + 1 || n_done != 1) begin
            failures++;
            $display("FAIL clear_done: got done_cyc=%0d last_wr=%0d dones=%0d want +1 and 1",
                     done_cyc, last_wr_cyc, n_done);
        end
        checks++;
        if (n_busy != 96001) begin
            failures++; $display("FAIL clear_busy: got %0d want 96001", n_busy);
        end
    endtask

    initial begin
        test_reset();
        test_draw(1'b0);
        test_draw(1'b1);
        test_transparent();
        test_stall();
        test_fill();
        test_zero_size();
        test_reset_mid_draw();
        test_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
